// File: rtl/nf10_upb_aurora_rx_buffer.sv
// Store-and-forward receive buffer behind the Aurora input stage: drops CRC-errored or
// overflowing packets, forwards complete good packets on AXIS, and drives pause flow control.
module nf10_upb_aurora_rx_buffer #(
  parameter int C_AXIS_DATA_WIDTH     = 256,
  parameter int C_PACKET_LENGTH_WIDTH = 14,
  parameter int C_DEPTH               = 512,
  parameter int C_HIGH_WM             = 384,
  parameter int C_LOW_WM              = 128,
  parameter int C_PAUSE_REFRESH       = 4096
) (
  input  logic                               axi_aclk,
  input  logic                               axi_resetn,
  input  logic [C_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]     s_axis_tkeep,
  input  logic [C_PACKET_LENGTH_WIDTH-1:0]   s_axis_tuser_packet_length,
  input  logic                               s_axis_tvalid,
  input  logic                               s_axis_tlast,
  input  logic                               s_axis_error,
  output logic [C_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]     m_axis_tkeep,
  output logic [C_PACKET_LENGTH_WIDTH-1:0]   m_axis_tuser_packet_length,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic                               m_axis_tlast,
  output logic                               flow_control_pause_req,
  output logic                               flow_control_pause_val,
  output logic [31:0]                        stat_crc_drops,
  output logic [31:0]                        stat_ovf_drops,
  output logic [$clog2(C_DEPTH):0]           fill_level
);

  localparam int AW = $clog2(C_DEPTH);
  localparam int PW = AW + 1;
  localparam int KW = C_AXIS_DATA_WIDTH / 8;
  localparam int MW = C_AXIS_DATA_WIDTH + KW + C_PACKET_LENGTH_WIDTH + 1;
  localparam int CW = (C_PAUSE_REFRESH > 1) ? $clog2(C_PAUSE_REFRESH) : 1;

  localparam logic [PW-1:0] DEPTH_P  = PW'(C_DEPTH);
  localparam logic [PW-1:0] HIGH_WM  = PW'(C_HIGH_WM);
  localparam logic [PW-1:0] LOW_WM   = PW'(C_LOW_WM);
  localparam logic [CW-1:0] RCNT_MAX = CW'((C_PAUSE_REFRESH > 0) ? C_PAUSE_REFRESH - 1 : 0);

  typedef enum logic [1:0] {W_IDLE, W_WRITE, W_DISCARD} wstate_t;
  typedef enum logic {P_RUN, P_PAUSED} pstate_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  wstate_t       wstate_q, wstate_d;
  pstate_t       pstate_q, pstate_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, commit_q, commit_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]   crc_q, crc_d, ovf_q, ovf_d;
  logic          vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
  logic          init_q, init_d, req_q, req_d, val_q, val_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic [MW-1:0] mem [C_DEPTH];
  logic [MW-1:0] word_p1_q, word_p2_q;
  logic [PW-1:0] occ;
  logic          full, mem_we, rd_en, out_load;

  assign occ      = wr_ptr_q - rd_ptr_q;
  assign full     = (occ == DEPTH_P);
  assign out_load = !vld_p2_q || m_axis_tready;
  // Only committed words are readable, so a packet still being written never leaks out.
  assign rd_en    = (rd_ptr_q != commit_q) && (!vld_p1_q || out_load);

  always_comb begin
    wstate_d = wstate_q;
    wr_ptr_d = wr_ptr_q;
    commit_d = commit_q;
    crc_d    = crc_q;
    ovf_d    = ovf_q;
    mem_we   = 1'b0;
    if (s_axis_tvalid) begin
      case (wstate_q)
        W_IDLE, W_WRITE: begin
          if (s_axis_error || full) begin
            wr_ptr_d = commit_q;
            if (s_axis_error) crc_d = sat_inc(crc_q);
            else              ovf_d = sat_inc(ovf_q);
            wstate_d = s_axis_tlast ? W_IDLE : W_DISCARD;
          end else begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (s_axis_tlast) begin
              commit_d = wr_ptr_q + 1'b1;
              wstate_d = W_IDLE;
            end else begin
              wstate_d = W_WRITE;
            end
          end
        end
        W_DISCARD: if (s_axis_tlast) wstate_d = W_IDLE;
        default:   wstate_d = W_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    vld_p1_d = rd_en ? 1'b1 : (out_load ? 1'b0 : vld_p1_q);
    vld_p2_d = out_load ? vld_p1_q : vld_p2_q;
  end

  always_comb begin
    pstate_d = pstate_q;
    init_d   = 1'b0;
    req_d    = 1'b0;
    val_d    = val_q;
    rcnt_d   = rcnt_q;
    if (init_q) begin
      req_d = 1'b1;
      val_d = 1'b0;
    end else begin
      case (pstate_q)
        P_RUN: if (occ >= HIGH_WM) begin
          pstate_d = P_PAUSED;
          req_d    = 1'b1;
          val_d    = 1'b1;
          rcnt_d   = '0;
        end
        P_PAUSED: begin
          if (occ < LOW_WM) begin
            pstate_d = P_RUN;
            req_d    = 1'b1;
            val_d    = 1'b0;
          end else if (C_PAUSE_REFRESH != 0) begin
            if (rcnt_q == RCNT_MAX) begin
              req_d  = 1'b1;
              val_d  = 1'b1;
              rcnt_d = '0;
            end else begin
              rcnt_d = rcnt_q + 1'b1;
            end
          end
        end
        default: pstate_d = P_RUN;
      endcase
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      wstate_q <= W_IDLE;
      pstate_q <= P_RUN;
      wr_ptr_q <= '0;
      commit_q <= '0;
      rd_ptr_q <= '0;
      crc_q    <= '0;
      ovf_q    <= '0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      init_q   <= 1'b1;
      req_q    <= 1'b0;
      val_q    <= 1'b0;
      rcnt_q   <= '0;
    end else begin
      wstate_q <= wstate_d;
      pstate_q <= pstate_d;
      wr_ptr_q <= wr_ptr_d;
      commit_q <= commit_d;
      rd_ptr_q <= rd_ptr_d;
      crc_q    <= crc_d;
      ovf_q    <= ovf_d;
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      init_q   <= init_d;
      req_q    <= req_d;
      val_q    <= val_d;
      rcnt_q   <= rcnt_d;
    end
  end

  // Stage p0 -> p1: synchronous RAM read; p1 -> p2: output register with hold under back-pressure.
  always_ff @(posedge axi_aclk) begin
    if (mem_we)
      mem[wr_ptr_q[AW-1:0]] <= {s_axis_tdata, s_axis_tkeep, s_axis_tuser_packet_length, s_axis_tlast};
    if (rd_en)
      word_p1_q <= mem[rd_ptr_q[AW-1:0]];
    if (out_load && vld_p1_q)
      word_p2_q <= word_p1_q;
  end

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser_packet_length, m_axis_tlast} = word_p2_q;
  assign m_axis_tvalid          = vld_p2_q;
  assign flow_control_pause_req = req_q;
  assign flow_control_pause_val = val_q;
  assign stat_crc_drops         = crc_q;
  assign stat_ovf_drops         = ovf_q;
  assign fill_level             = occ;

endmodule

// File: tb/tb_nf10_upb_aurora_rx_buffer.sv
// Self-checking bench: three buffer instances share one input stream; a packet-level
// scoreboard predicts forwarded beats, drop counters and pause strobe timing.
module tb_nf10_upb_aurora_rx_buffer;
  localparam int DW = 64, KW = 8, LW = 14;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [LW-1:0] l;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rstn, s_tvalid, s_tlast, s_err, tready;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic [LW-1:0] s_tlen;

  logic [DW-1:0] a_tdata, b_tdata, c_tdata;
  logic [KW-1:0] a_tkeep, b_tkeep, c_tkeep;
  logic [LW-1:0] a_tlen, b_tlen, c_tlen;
  logic a_tvalid, b_tvalid, c_tvalid, a_tlast, b_tlast, c_tlast;
  logic a_req, b_req, c_req, a_val, b_val, c_val;
  logic [31:0] a_crc, b_crc, c_crc, a_ovf, b_ovf, c_ovf;
  logic [9:0] a_fill;
  logic [4:0] b_fill, c_fill;

  nf10_upb_aurora_rx_buffer #(.C_AXIS_DATA_WIDTH(DW)) dut_a (
    .axi_aclk(clk), .axi_resetn(rstn), .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
    .s_axis_tuser_packet_length(s_tlen), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_error(s_err), .m_axis_tdata(a_tdata), .m_axis_tkeep(a_tkeep),
    .m_axis_tuser_packet_length(a_tlen), .m_axis_tvalid(a_tvalid), .m_axis_tready(tready),
    .m_axis_tlast(a_tlast), .flow_control_pause_req(a_req), .flow_control_pause_val(a_val),
    .stat_crc_drops(a_crc), .stat_ovf_drops(a_ovf), .fill_level(a_fill));

  nf10_upb_aurora_rx_buffer #(.C_AXIS_DATA_WIDTH(DW), .C_DEPTH(16), .C_HIGH_WM(12),
    .C_LOW_WM(4), .C_PAUSE_REFRESH(0)) dut_b (
    .axi_aclk(clk), .axi_resetn(rstn), .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
    .s_axis_tuser_packet_length(s_tlen), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_error(s_err), .m_axis_tdata(b_tdata), .m_axis_tkeep(b_tkeep),
    .m_axis_tuser_packet_length(b_tlen), .m_axis_tvalid(b_tvalid), .m_axis_tready(tready),
    .m_axis_tlast(b_tlast), .flow_control_pause_req(b_req), .flow_control_pause_val(b_val),
    .stat_crc_drops(b_crc), .stat_ovf_drops(b_ovf), .fill_level(b_fill));

  nf10_upb_aurora_rx_buffer #(.C_AXIS_DATA_WIDTH(DW), .C_DEPTH(16), .C_HIGH_WM(12),
    .C_LOW_WM(4), .C_PAUSE_REFRESH(8)) dut_c (
    .axi_aclk(clk), .axi_resetn(rstn), .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
    .s_axis_tuser_packet_length(s_tlen), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_error(s_err), .m_axis_tdata(c_tdata), .m_axis_tkeep(c_tkeep),
    .m_axis_tuser_packet_length(c_tlen), .m_axis_tvalid(c_tvalid), .m_axis_tready(tready),
    .m_axis_tlast(c_tlast), .flow_control_pause_req(c_req), .flow_control_pause_val(c_val),
    .stat_crc_drops(c_crc), .stat_ovf_drops(c_ovf), .fill_level(c_fill));

  beat_t exp_q[$], got_q[$];
  int    got_cyc[$], bs_cyc[$], cs_cyc[$];
  bit    bs_val[$], cs_val[$];
  int    sel = 0;
  bit    rnd_rdy = 0;
  int    last_edge = 0;
  int    n_assert = 0, n_fail = 0;

  always @(negedge clk) begin
    if (sel == 0 && a_tvalid && tready) begin
      got_q.push_back({a_tdata, a_tkeep, a_tlen, a_tlast});
      got_cyc.push_back(cyc);
    end
    if (sel == 1 && b_tvalid && tready) begin
      got_q.push_back({b_tdata, b_tkeep, b_tlen, b_tlast});
      got_cyc.push_back(cyc);
    end
    if (b_req) begin bs_cyc.push_back(cyc); bs_val.push_back(b_val); end
    if (c_req) begin cs_cyc.push_back(cyc); cs_val.push_back(c_val); end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic rnd_tready();
    if (rnd_rdy) tready = 1'($urandom_range(1));
  endtask

  task automatic clear_q();
    exp_q.delete(); got_q.delete(); got_cyc.delete();
    bs_cyc.delete(); bs_val.delete(); cs_cyc.delete(); cs_val.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      s_tvalid = 1'b0; s_tlast = 1'b0; s_err = 1'b0;
      rnd_tready();
    end
  endtask

  task automatic send_pkt(input int n, input int err_at, input bit keep_it, input int gap);
    int sh;
    sh = $urandom_range(7);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      if (gap > 0 && $urandom_range(99) < gap) idle(1);
      b.d    = {$urandom, $urandom};
      b.k    = (i == n - 1) ? (8'hFF >> sh) : 8'hFF;
      b.l    = LW'((n - 1) * 8 + (8 - sh));
      b.last = (i == n - 1);
      @(posedge clk); #1;
      s_tdata = b.d; s_tkeep = b.k; s_tlen = b.l; s_tlast = b.last;
      s_err = (i == err_at); s_tvalid = 1'b1;
      rnd_tready();
      if (b.last) last_edge = cyc + 1;
      if (keep_it) exp_q.push_back(b);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstn = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_err = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); @(negedge clk); #1;
    clear_q();
  endtask

  task automatic wait_drain();
    int t = 0;
    while (got_q.size() < exp_q.size() && t < 2000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic compare_beats(input string tag);
    int n;
    chk({tag, " beat count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s beat %0d", tag, i), got_q[i], exp_q[i]);
  endtask

  initial begin
    int t1, n_crc_exp, len, ea;
    rstn = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_err = 1'b0;
    s_tdata = '0; s_tkeep = '0; s_tlen = '0; tready = 1'b1;

    // Reset state and the post-reset resume strobe
    repeat (3) @(posedge clk);
    #1;
    chk("rst tvalid", a_tvalid, 0);
    chk("rst fill", a_fill, 0);
    chk("rst req", a_req, 0);
    chk("rst val", a_val, 0);
    chk("rst crc", a_crc, 0);
    chk("rst ovf", a_ovf, 0);
    rstn = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("init resume req", a_req, 1);
    chk("init resume val", a_val, 0);
    @(negedge clk);
    chk("init req single", a_req, 0);
    #1 clear_q();

    // Three good packets, 4/1/7 beats, continuous tready
    sel = 0;
    send_pkt(4, -1, 1, 0);
    t1 = last_edge;
    send_pkt(1, -1, 1, 0);
    send_pkt(7, -1, 1, 0);
    idle(1);
    wait_drain();
    compare_beats("t1");
    chk("t1 latency", (got_cyc.size() > 0) ? got_cyc[0] - t1 : -1, 2);
    chk("t1 crc", a_crc, 0);
    chk("t1 ovf", a_ovf, 0);
    chk("t1 fill", a_fill, 0);
    clear_q();

    // CRC error mid-packet, followed by a good packet
    send_pkt(5, 2, 0, 0);
    send_pkt(2, -1, 1, 0);
    idle(1);
    wait_drain();
    compare_beats("t2");
    chk("t2 crc", a_crc, 1);
    chk("t2 ovf", a_ovf, 0);
    chk("t2 fill", a_fill, 0);
    clear_q();

    // Random packets, random errors and gaps, random back-pressure
    n_crc_exp = 1;
    rnd_rdy = 1;
    for (int p = 0; p < 30; p++) begin
      len = $urandom_range(8, 1);
      ea  = ($urandom_range(4) == 0) ? int'($urandom_range(len - 1)) : -1;
      if (ea >= 0) n_crc_exp++;
      send_pkt(len, ea, ea < 0, 30);
    end
    idle(1);
    rnd_rdy = 0;
    tready = 1'b1;
    wait_drain();
    compare_beats("rand");
    chk("rand crc", a_crc, n_crc_exp);
    chk("rand ovf", a_ovf, 0);
    chk("rand fill", a_fill, 0);

    // Overflow on a 16-deep buffer, then a packet that fits
    do_reset();
    sel = 1;
    tready = 1'b0;
    send_pkt(20, -1, 0, 0);
    idle(1);
    @(negedge clk);
    chk("t3 fill after drop", b_fill, 0);
    chk("t3 ovf", b_ovf, 1);
    chk("t3 crc", b_crc, 0);
    send_pkt(4, -1, 1, 0);
    idle(1);
    repeat (3) @(negedge clk);
    chk("t3 no output under stall", got_q.size(), 0);
    tready = 1'b1;
    wait_drain();
    compare_beats("t3");
    chk("t3 fill end", b_fill, 0);

    // Watermark pause/resume (dut_b) and pause refresh every 8 cycles (dut_c)
    do_reset();
    tready = 1'b0;
    send_pkt(12, -1, 1, 0);
    idle(1);
    repeat (30) @(negedge clk);
    chk("t4 pause strobes", bs_cyc.size(), 1);
    chk("t4 pause timing", (bs_cyc.size() > 0) ? bs_cyc[0] : -1, last_edge + 1);
    chk("t4 pause strobe val", (bs_val.size() > 0) ? bs_val[0] : 1'b0, 1);
    chk("t4 val held", b_val, 1);
    chk("t5 strobe count", cs_cyc.size(), 4);
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("t5 refresh %0d", i), (cs_cyc.size() > i) ? cs_cyc[i] - cs_cyc[0] : -1, 8 * i);
      chk($sformatf("t5 refresh val %0d", i), (cs_val.size() > i) ? cs_val[i] : 1'b0, 1);
    end
    tready = 1'b1;
    wait_drain();
    compare_beats("t4");
    chk("t4 total strobes", bs_cyc.size(), 2);
    chk("t4 resume val", (bs_val.size() > 1) ? bs_val[1] : 1'b1, 0);
    chk("t4 val after drain", b_val, 0);
    chk("t4 fill end", b_fill, 0);
    chk("t5 resumed", c_val, 0);

    // Asynchronous reset mid-packet and mid-output
    do_reset();
    sel = 0;
    tready = 1'b1;
    send_pkt(3, 0, 0, 0);
    tready = 1'b0;
    send_pkt(6, -1, 0, 0);
    repeat (2) begin
      @(posedge clk); #1;
      s_tdata = {$urandom, $urandom}; s_tkeep = '1; s_tlast = 1'b0; s_err = 1'b0; s_tvalid = 1'b1;
    end
    @(posedge clk); #2;
    chk("t6 mid-output valid", a_tvalid, 1);
    chk("t6 crc before reset", a_crc, 1);
    rstn = 1'b0;
    #1;
    chk("t6 async tvalid", a_tvalid, 0);
    chk("t6 async fill", a_fill, 0);
    chk("t6 async crc", a_crc, 0);
    chk("t6 async req", a_req, 0);
    chk("t6 async val", a_val, 0);
    s_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("t6 resume req", a_req, 1);
    chk("t6 resume val", a_val, 0);
    @(negedge clk);
    chk("t6 resume single", a_req, 0);
    #1 clear_q();
    tready = 1'b1;
    send_pkt(5, -1, 1, 0);
    idle(1);
    wait_drain();
    compare_beats("t6");
    chk("t6 fill end", a_fill, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
